// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared constants for the EX-stage forwarding / hazard unit:
//               operand-select encodings and the hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  // Default register address width of the MIPS register file
  localparam int REG_AW = 5;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // result of the instruction in WB
  localparam logic [1:0] FWD_MEM = 2'b10;  // result of the instruction in MEM

  // $0 is hard-wired to zero and never produces a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_src_cmp.sv
`default_nettype none
// ============================================================================
// Module      : fwd_src_cmp
// Description : Forwarding select for one ID source register. Compares the
//               source against the EX and MEM destinations; the newer (EX)
//               producer wins. A $0 source never matches.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_src_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_we,
  output logic [1:0]        sel
);
  import fwd_pkg::*;

  logic src_nz;
  logic ex_hit;
  logic mem_hit;

  assign src_nz  = (src != REG_AW'(REG_ZERO));
  assign ex_hit  = ex_we  && (ex_dest  == src) && src_nz;
  assign mem_hit = mem_we && (mem_dest == src) && src_nz;

  // Priority select: the EX producer is newer than the MEM producer
  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_MEM;   // EX instruction will sit in MEM next cycle
    end else if (mem_hit) begin
      sel = FWD_WB;    // MEM instruction will sit in WB next cycle
    end
  end

endmodule : fwd_src_cmp
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Tracks the EX write destination through MEM and WB, produces
//               registered ALU-operand forwarding selects for the next EX
//               cycle and a combinational load-use stall.
//               Optional macro FWD_STALL_CNT_EN: saturating stall-cycle counter
//               on stall_cnt (tied to zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);
  import fwd_pkg::*;

  // Stage tracking registers
  logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
  logic              mem_we_q,   mem_we_d;
  logic              mem_ld_q,   mem_ld_d;
  logic [REG_AW-1:0] wb_dest_q,  wb_dest_d;
  logic              wb_we_q,    wb_we_d;

  // Registered forwarding selects
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       ex_dest_nz;
  logic       load_hit;
  logic       bubble;

  // WB stage and load flag are carried for pipeline observability only;
  // the register file writes before it reads, so a WB match needs no bypass.
  logic unused_tracking;
  assign unused_tracking = ^{mem_ld_q, wb_dest_q, wb_we_q};

  // Per-source priority compare against EX and MEM producers
  fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .src      (id_rs),
    .ex_dest  (ex_dest),
    .ex_we    (ex_regwrite),
    .mem_dest (mem_dest_q),
    .mem_we   (mem_we_q),
    .sel      (sel_a)
  );

  fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .src      (id_rt),
    .ex_dest  (ex_dest),
    .ex_we    (ex_regwrite),
    .mem_dest (mem_dest_q),
    .mem_we   (mem_we_q),
    .sel      (sel_b)
  );

  // Load-use: a load in EX feeds a source the ID instruction actually reads
  assign ex_dest_nz = (ex_dest != REG_AW'(REG_ZERO));
  assign load_hit   = ex_memread && ex_regwrite && ex_dest_nz &&
                      ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
  // Flush dominates: a killed instruction never stalls
  assign stall      = !reset && id_valid && !flush && load_hit;

  // Instruction entering EX next cycle is a bubble
  assign bubble     = stall || flush || !id_valid;

  // Next-state: stage tracking shifts every cycle, selects follow ID
  always_comb begin
    mem_dest_d = ex_dest;
    mem_we_d   = ex_regwrite;
    mem_ld_d   = ex_memread;
    wb_dest_d  = mem_dest_q;
    wb_we_d    = mem_we_q;
    fwd_a_d    = FWD_RF;
    fwd_b_d    = FWD_RF;
    if (!bubble) begin
      fwd_a_d = sel_a;
      fwd_b_d = id_uses_rt ? sel_b : FWD_RF;
    end
  end

  // Pipeline and select registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_dest_q <= '0;
      mem_we_q   <= 1'b0;
      mem_ld_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_we_q    <= 1'b0;
      fwd_a_q    <= FWD_RF;
      fwd_b_q    <= FWD_RF;
    end else begin
      mem_dest_q <= mem_dest_d;
      mem_we_q   <= mem_we_d;
      mem_ld_q   <= mem_ld_d;
      wb_dest_q  <= wb_dest_d;
      wb_we_q    <= wb_we_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule : fwd_hazard_unit
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Directed-vector bench for fwd_hazard_unit. The driver pushes
//               hand-computed expectations into a scoreboard queue tagged with
//               the cycle they are due; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_dest     (ex_dest),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .flush       (flush),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry: sig 0=stall 1=fwd_a 2=fwd_b 3=stall_cnt
  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
    int          vec;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Bench-side model of the optional counter
  int  exp_cnt   = 0;
  bit  cnt_known = 1'b0;

  function automatic string sig_name(input int s);
    case (s)
      0:       return "stall";
      1:       return "fwd_a";
      2:       return "fwd_b";
      default: return "stall_cnt";
    endcase
  endfunction

  // Monitor: compare every entry that falls due this cycle
  always @(negedge clk) begin
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      case (e.sig)
        0:       act = {31'd0, stall};
        1:       act = {30'd0, fwd_a};
        2:       act = {30'd0, fwd_b};
        default: act = {16'd0, stall_cnt};
      endcase
      checks++;
      if (e.due != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL vec%0d %s: got %0h expected %0h (due cyc %0d, now %0d)",
                 e.vec, sig_name(e.sig), act, e.exp, e.due, cyc);
      end
    end
  end

  task automatic drive(input int id, input logic rst_i,
                       input logic [4:0] ed, input logic rw, input logic mr,
                       input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic fl,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb);
    sb_t e;
    @(posedge clk);
    #1;
    reset = rst_i; ex_dest = ed; ex_regwrite = rw; ex_memread = mr;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ur; flush = fl;
    e.vec = id;
    e.due = cyc;     e.sig = 0; e.exp = {31'd0, es}; sb.push_back(e);
    if (cnt_known) begin
`ifdef FWD_STALL_CNT_EN
      e.exp = exp_cnt;
`else
      e.exp = 32'd0;
`endif
      e.sig = 3; sb.push_back(e);
    end
    e.due = cyc + 1; e.sig = 1; e.exp = {30'd0, ea}; sb.push_back(e);
    e.due = cyc + 1; e.sig = 2; e.exp = {30'd0, eb}; sb.push_back(e);
    if (rst_i) begin
      exp_cnt   = 0;
      cnt_known = 1'b1;
    end else if (es && exp_cnt < 65535) begin
      exp_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; ex_dest = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; flush = 1'b0;

    //     id rst ed  rw mr v  rs  rt  ur fl  stall fa     fb
    // Reset held with a live load-use match: stall suppressed, selects clear
    drive( 1, 1, 5,  1, 1, 1, 5,  0,  0, 0,  0, 2'b00, 2'b00);
    drive( 2, 1, 5,  1, 1, 1, 5,  0,  0, 0,  0, 2'b00, 2'b00);
    // Release: load-use stall on rs
    drive( 3, 0, 5,  1, 1, 1, 5,  0,  0, 0,  1, 2'b00, 2'b00);
    // Bubble in EX, load now in MEM -> WB select
    drive( 4, 0, 0,  0, 0, 1, 5,  0,  0, 0,  0, 2'b01, 2'b00);
    // add $8 in EX, ID rs=8 rt=9 -> MEM select on A only
    drive( 5, 0, 8,  1, 0, 1, 8,  9,  1, 0,  0, 2'b10, 2'b00);
    // $8 now in MEM -> WB select on A
    drive( 6, 0, 12, 1, 0, 1, 8,  3,  1, 0,  0, 2'b01, 2'b00);
    // A from MEM ($12), B from EX ($8)
    drive( 7, 0, 8,  1, 0, 1, 12, 8,  1, 0,  0, 2'b01, 2'b10);
    // Double hazard: EX and MEM both write $8 -> EX wins
    drive( 8, 0, 8,  1, 0, 1, 8,  7,  1, 0,  0, 2'b10, 2'b00);
    // Load-use on rt
    drive( 9, 0, 10, 1, 1, 1, 4,  10, 1, 0,  1, 2'b00, 2'b00);
    drive(10, 0, 0,  0, 0, 1, 4,  10, 1, 0,  0, 2'b00, 2'b01);
    // $0 never a hazard: EX load to $0, ID reads $0
    drive(11, 0, 0,  1, 1, 1, 0,  0,  1, 0,  0, 2'b00, 2'b00);
    // $0 sitting in MEM with we set
    drive(12, 0, 0,  1, 0, 1, 0,  0,  1, 0,  0, 2'b00, 2'b00);
    // rt match masked by id_uses_rt=0
    drive(13, 0, 6,  1, 0, 1, 3,  6,  0, 0,  0, 2'b00, 2'b00);
    drive(14, 0, 6,  1, 1, 1, 3,  6,  0, 0,  0, 2'b00, 2'b00);
    // id_valid=0 with load-use match
    drive(15, 0, 7,  1, 1, 0, 7,  0,  0, 0,  0, 2'b00, 2'b00);
    // Flush during load-use match
    drive(16, 0, 10, 1, 1, 1, 10, 0,  0, 1,  0, 2'b00, 2'b00);
    // mem_dest advanced despite flush
    drive(17, 0, 0,  0, 0, 1, 10, 0,  0, 0,  0, 2'b01, 2'b00);
    drive(18, 0, 0,  0, 0, 1, 10, 0,  0, 0,  0, 2'b00, 2'b00);
    // Flush kills an ALU forward
    drive(19, 0, 9,  1, 0, 1, 9,  0,  0, 1,  0, 2'b00, 2'b00);
    // Mid-run reset with a load-use match, then MEM must be clear
    drive(20, 1, 9,  1, 1, 1, 9,  0,  0, 0,  0, 2'b00, 2'b00);
    drive(21, 0, 0,  0, 0, 1, 9,  0,  0, 0,  0, 2'b00, 2'b00);
    drive(22, 0, 0,  0, 0, 0, 0,  0,  0, 0,  0, 2'b00, 2'b00);

    // Let the monitor drain, bounded
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_fwd_hazard_unit
`default_nettype wire
